spi_word_rx: RTL and testbench
==============================

// Module: spi_word_rx
// PURPOSE
//  SPI slave front end, upstream of the data interpreter. Oversamples SCK/CS_N/MOSI in the clk domain.
//  Assembles MSB-first 32-bit command words onto DATA and pulses DATA_READY once per complete word.
//  Downstream decodes the word into WE/RE/WCLK/RDATA. Mode 0 only (CPOL=0, CPHA=0).
// PARAMETERS
//  WORD_WIDTH   32  bits per word; DATA width
//  SYNC_STAGES  2   flops per input synchronizer (>=2)
// PORTS
//  clk         in   1           system clock; must be >= 8x SCK frequency
//  rst_n       in   1           asynchronous, active-low reset
//  SCK         in   1           SPI clock (async to clk)
//  CS_N        in   1           SPI chip select, active low (async)
//  MOSI        in   1           SPI data in (async)
//  MISO        out  1           SPI data out (see CONFIGURATION)
//  TX_DATA     in   WORD_WIDTH  word returned on MISO during the next word
//  DATA        out  WORD_WIDTH  last complete received word; held until the next one completes
//  DATA_READY  out  1           one-clk pulse: DATA has just been updated
//  FRAME_ERR   out  1           one-clk pulse: CS_N rose with a partial word
// BEHAVIOUR
//  Reset (rst_n low, async): DATA=0, DATA_READY=0, FRAME_ERR=0, MISO=0.
//    Also: bit_cnt=0, shift=0, state=IDLE, all sync flops=idle level (SCK=0, CS_N=1, MOSI=0).
//  Inputs pass SYNC_STAGES flops, then one flop for edge detect. sck_rise/sck_fall/cs_fall/cs_rise are 1-clk strobes.
//  FSM IDLE: CS_N high. On cs_fall -> ACTIVE; bit_cnt=0; shift=0; load TX shadow.
//  FSM ACTIVE, on sck_rise:
//    shift <= {shift[WORD_WIDTH-2:0], mosi_s}; bit_cnt++.
//    On the WORD_WIDTH-th bit: DATA <= completed word; DATA_READY=1 for one clk; bit_cnt wraps to 0.
//    Stays in ACTIVE, so back-to-back words within one CS are legal.
//  FSM ACTIVE, on cs_rise -> IDLE.
//    bit_cnt!=0: partial word discarded; DATA unchanged; FRAME_ERR pulses.
//    bit_cnt==0: no pulse.
//  Latency: DATA_READY asserts exactly SYNC_STAGES+2 clk edges after the final SCK rising edge reaches the pin.
//    DATA is valid in the same cycle as DATA_READY.
//  DATA stability: DATA is never written except on word completion.
//    The clk>=8x SCK rule guarantees >=4 clk of stable DATA after DATA_READY falls (downstream samples 3 clk later).
//  Simultaneous sck_rise and cs_rise: the sck_rise is processed first.
//    If that completes the word, it gives DATA_READY and no FRAME_ERR.
//  sck_rise while IDLE: ignored.
//  cs_fall while ACTIVE (glitch): impossible after sync; treated as a no-op.
//  Reset mid-word: the word is discarded silently; no pulse after release.
//  DATA_READY and FRAME_ERR are never high in the same cycle.
// CONFIGURATION
//  SPI_MISO_EN defined:
//    tx_shift loads TX_DATA on cs_fall and on each word completion.
//    MISO = tx_shift MSB, updated on sck_fall, so the first bit is valid before the first SCK rise.
//    MISO=0 while CS_N high.
//  SPI_MISO_EN undefined: MISO tied 0; TX_DATA ignored; no tx_shift logic; all other behaviour identical.
// STRUCTURE
//  Shared header spi_defs.vh: WORD_WIDTH default, FSM state encodings (ST_IDLE, ST_ACTIVE), SPI mode constant.
//  Sub-module sync_bit (SYNC_STAGES-deep async-reset synchronizer, reset value param).
//    Instanced for SCK, CS_N and MOSI. The rest stays flat in spi_word_rx.
// TESTING (clk period 2, SCK period 16, bench drives SPI pins)
//  1 Single word 0x8040A4A4 -> DATA=0x8040A4A4.
//    One DATA_READY pulse at SYNC_STAGES+2 clk after the 32nd SCK rise; FRAME_ERR stays 0.
//  2 Two words 0x0040A4A4, 0xCA33A3A3 in one CS.
//    -> Two DATA_READY pulses ~32 SCK apart; DATA holds 0x0040A4A4 between them.
//  3 CS_N rises after 13 bits of 0xFFFFFFFF following 0x12345678.
//    -> FRAME_ERR one pulse, no DATA_READY, DATA stays 0x12345678.
//    Next full word 0x8040A4A4 is received correctly.
//  4 rst_n pulsed low after 20 bits -> outputs 0 immediately (async).
//    After release, a fresh word 0x00000001 gives DATA=0x00000001 with one pulse.
//  5 SCK toggled with CS_N high -> no DATA_READY, no FRAME_ERR, DATA unchanged.
//  6 [SPI_MISO_EN] TX_DATA=0xA5A50F0F; transfer any word -> MISO bitstream sampled on SCK rise = 0xA5A50F0F.
//    Without the macro, MISO=0 throughout.

Source files
------------

// File: rtl/spi_word_rx_pkg.sv
// Shared definitions for the SPI word receiver: default word width, FSM states, SPI mode.
package spi_word_rx_pkg;

   localparam int WORD_WIDTH_DEF = 32;
   localparam int SPI_MODE       = 0;   // CPOL=0, CPHA=0

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

endpackage

// File: rtl/spi_word_rx_sync_bit.sv
// Multi-flop synchronizer for one asynchronous input, with a configurable reset (idle) level.
module spi_word_rx_sync_bit #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_word_rx.sv
// SPI mode-0 slave word receiver: oversampled SCK/CS_N/MOSI, MSB-first words onto DATA.
// Optional MISO return path enabled by defining SPI_MISO_EN.
module spi_word_rx
   import spi_word_rx_pkg::*;
#(
   parameter int WORD_WIDTH  = WORD_WIDTH_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  SCK,
   input  logic                  CS_N,
   input  logic                  MOSI,
   output logic                  MISO,
   input  logic [WORD_WIDTH-1:0] TX_DATA,
   output logic [WORD_WIDTH-1:0] DATA,
   output logic                  DATA_READY,
   output logic                  FRAME_ERR
);

   localparam int              CW       = $clog2(WORD_WIDTH);
   localparam logic [CW-1:0]   LAST_BIT = CW'(WORD_WIDTH - 1);

   logic sck_s, cs_s, mosi_s;

   spi_word_rx_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .clk(clk), .rst_n(rst_n), .d_i(SCK), .q_o(sck_s));
   spi_word_rx_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst_n(rst_n), .d_i(CS_N), .q_o(cs_s));
   spi_word_rx_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst_n(rst_n), .d_i(MOSI), .q_o(mosi_s));

   // Edge detect is a registered strobe stage, so events reach the FSM SYNC_STAGES+1 edges after the pin.
   logic sck_e_q, cs_e_q;
   logic sck_rise_q, sck_fall_q, cs_rise_q, cs_fall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_e_q    <= 1'b0;
         cs_e_q     <= 1'b1;
         sck_rise_q <= 1'b0;
         sck_fall_q <= 1'b0;
         cs_rise_q  <= 1'b0;
         cs_fall_q  <= 1'b0;
      end else begin
         sck_e_q    <= sck_s;
         cs_e_q     <= cs_s;
         sck_rise_q <= sck_s & ~sck_e_q;
         sck_fall_q <= ~sck_s & sck_e_q;
         cs_rise_q  <= cs_s & ~cs_e_q;
         cs_fall_q  <= ~cs_s & cs_e_q;
      end
   end

   spi_state_e            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [WORD_WIDTH-1:0] shift_q, shift_d;
   logic [WORD_WIDTH-1:0] data_q, data_d;
   logic                  ready_q, ready_d;
   logic                  ferr_q, ferr_d;
   logic                  word_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         ferr_q  <= ferr_d;
      end
   end

   assign word_done = (state_q == ST_ACTIVE) && sck_rise_q && (cnt_q == LAST_BIT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      data_d  = data_q;
      ready_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cs_fall_q) begin
               state_d = ST_ACTIVE;
               cnt_d   = '0;
               shift_d = '0;
            end
         end
         ST_ACTIVE: begin
            if (sck_rise_q) begin
               shift_d = {shift_q[WORD_WIDTH-2:0], mosi_s};
               if (word_done) begin
                  data_d  = shift_d;
                  ready_d = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            // The SCK rise of this cycle is already folded into cnt_d, so a completing bit suppresses FRAME_ERR.
            if (cs_rise_q) begin
               state_d = ST_IDLE;
               ferr_d  = (cnt_d != '0);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign DATA       = data_q;
   assign DATA_READY = ready_q;
   assign FRAME_ERR  = ferr_q;

`ifdef SPI_MISO_EN
   logic [WORD_WIDTH-1:0] tx_q, tx_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_q <= '0;
      end else begin
         tx_q <= tx_d;
      end
   end

   // No shift on the fall after a word's last bit: the freshly loaded word's MSB must stay on MISO.
   always_comb begin
      tx_d = tx_q;
      if (state_q == ST_IDLE) begin
         if (cs_fall_q) tx_d = TX_DATA;
      end else if (word_done) begin
         tx_d = TX_DATA;
      end else if (sck_fall_q && (cnt_q != '0)) begin
         tx_d = {tx_q[WORD_WIDTH-2:0], 1'b0};
      end
   end

   assign MISO = (state_q == ST_ACTIVE) ? tx_q[WORD_WIDTH-1] : 1'b0;
`else
   logic unused_tx;
   assign unused_tx = ^{TX_DATA, sck_fall_q};
   assign MISO      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_word_rx.sv
// Directed bench for spi_word_rx: clk period 2, SCK period 16, SPI pins driven on clk falling edges.
`timescale 1ns/1ps
module tb_spi_word_rx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        SCK, CS_N, MOSI;
   logic        MISO;
   logic [31:0] TX_DATA;
   logic [31:0] DATA;
   logic        DATA_READY, FRAME_ERR;

   int  n_assert = 0;
   int  n_fail   = 0;
   int  rdy_cnt  = 0;
   int  ferr_cnt = 0;
   int  both_cnt = 0;
   time last_rise_t  = 0;
   time last_ready_t = 0;
   time prev_ready_t = 0;
   logic [31:0] miso_word;

   always #1 clk = ~clk;

   spi_word_rx #(.WORD_WIDTH(32), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .SCK       (SCK),
      .CS_N      (CS_N),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .TX_DATA   (TX_DATA),
      .DATA      (DATA),
      .DATA_READY(DATA_READY),
      .FRAME_ERR (FRAME_ERR)
   );

   always @(negedge clk) begin
      if (DATA_READY) begin
         rdy_cnt++;
         prev_ready_t = last_ready_t;
         last_ready_t = $time;
      end
      if (FRAME_ERR) ferr_cnt++;
      if (DATA_READY && FRAME_ERR) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         MOSI = w[31-i];
         #8;
         miso_word   = {miso_word[30:0], MISO};
         SCK         = 1'b1;
         last_rise_t = $time;
         #8;
         SCK = 1'b0;
      end
   endtask

   initial begin
      int r0, f0;
      rst_n = 1'b0; SCK = 1'b0; CS_N = 1'b1; MOSI = 1'b0; TX_DATA = 32'h0; miso_word = 32'h0;
      #4;
      check("reset_data",  DATA, 32'h0);
      check("reset_ready", {31'h0, DATA_READY}, 32'h0);
      check("reset_ferr",  {31'h0, FRAME_ERR}, 32'h0);
      check("reset_miso",  {31'h0, MISO}, 32'h0);
      #2 rst_n = 1'b1;
      #20;

      // 1: single word, latency SYNC_STAGES+2 = 4 clk = 8 ns after final rise
      r0 = rdy_cnt; f0 = ferr_cnt;
      CS_N = 1'b0;
      send_word(32'h8040A4A4, 32);
      #20;
      CS_N = 1'b1;
      #20;
      check("t1_data",    DATA, 32'h8040A4A4);
      check("t1_rdy_cnt", rdy_cnt - r0, 1);
      check("t1_ferr",    ferr_cnt - f0, 0);
      check("t1_latency", 32'(last_ready_t - last_rise_t), 8);

      // 2: back-to-back words in one CS
      r0 = rdy_cnt; f0 = ferr_cnt;
      CS_N = 1'b0;
      send_word(32'h0040A4A4, 32);
      #20;
      check("t2_hold_first", DATA, 32'h0040A4A4);
      send_word(32'hCA33A3A3, 32);
      #20;
      check("t2_data2",   DATA, 32'hCA33A3A3);
      check("t2_rdy_cnt", rdy_cnt - r0, 2);
      check("t2_spacing", 32'(last_ready_t - prev_ready_t), 532);
      CS_N = 1'b1;
      #20;
      check("t2_ferr", ferr_cnt - f0, 0);

      // 3: partial word after a good one
      r0 = rdy_cnt; f0 = ferr_cnt;
      CS_N = 1'b0;
      send_word(32'h12345678, 32);
      send_word(32'hFFFFFFFF, 13);
      #8;
      CS_N = 1'b1;
      #20;
      check("t3_ferr_cnt", ferr_cnt - f0, 1);
      check("t3_rdy_cnt",  rdy_cnt - r0, 1);
      check("t3_data",     DATA, 32'h12345678);
      r0 = rdy_cnt; f0 = ferr_cnt;
      CS_N = 1'b0;
      send_word(32'h8040A4A4, 32);
      #20;
      CS_N = 1'b1;
      #20;
      check("t3_next_data", DATA, 32'h8040A4A4);
      check("t3_next_rdy",  rdy_cnt - r0, 1);
      check("t3_next_ferr", ferr_cnt - f0, 0);

      // 4: async reset mid-word
      CS_N = 1'b0;
      send_word(32'hDEADBEEF, 20);
      #2 rst_n = 1'b0;
      #1;
      check("t4_rst_data",  DATA, 32'h0);
      check("t4_rst_ready", {31'h0, DATA_READY}, 32'h0);
      check("t4_rst_ferr",  {31'h0, FRAME_ERR}, 32'h0);
      #1 CS_N = 1'b1;
      #10 rst_n = 1'b1;
      r0 = rdy_cnt; f0 = ferr_cnt;
      #40;
      check("t4_post_rdy",  rdy_cnt - r0, 0);
      check("t4_post_ferr", ferr_cnt - f0, 0);
      CS_N = 1'b0;
      send_word(32'h00000001, 32);
      #20;
      CS_N = 1'b1;
      #20;
      check("t4_new_data", DATA, 32'h00000001);
      check("t4_new_rdy",  rdy_cnt - r0, 1);
      check("t4_new_ferr", ferr_cnt - f0, 0);

      // 5: SCK activity with CS_N high
      r0 = rdy_cnt; f0 = ferr_cnt;
      send_word(32'hFFFFFFFF, 32);
      #20;
      check("t5_rdy",  rdy_cnt - r0, 0);
      check("t5_ferr", ferr_cnt - f0, 0);
      check("t5_data", DATA, 32'h00000001);

      // 6: MISO return path
      TX_DATA   = 32'hA5A50F0F;
      miso_word = 32'h0;
      CS_N = 1'b0;
      send_word(32'h3C3C3C3C, 32);
      #20;
`ifdef SPI_MISO_EN
      check("t6_miso_word", miso_word, 32'hA5A50F0F);
`else
      check("t6_miso_word", miso_word, 32'h0);
`endif
      check("t6_data", DATA, 32'h3C3C3C3C);
      CS_N = 1'b1;
      #20;
      check("t6_miso_idle", {31'h0, MISO}, 32'h0);

      check("never_both", both_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
